// File: rtl/photon_hash_ctrl_pkg.sv
// Shared types for the PHOTON hash controller: opcodes, FSM states, address width helper.
package photon_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_WRITE = 3'd1,
        OP_READ  = 3'd2,
        OP_HASH  = 3'd3,
        OP_CLEAR = 3'd4
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/photon_hash_ctrl_if.sv
// Command/readback bus plus permutation-core handshake of the PHOTON hash controller.
interface photon_hash_ctrl_if
    import photon_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NWORDS = 8
);
    localparam int unsigned ADDR_W = addr_w(NWORDS);

    logic [2:0]               opcode;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        data_in;
    logic [DATA_W-1:0]        data_out;
    logic                     ready;
    logic                     busy;
    logic                     err;
    logic                     perm_start;
    logic [NWORDS*DATA_W-1:0] perm_state_o;
    logic [NWORDS*DATA_W-1:0] perm_state_i;
    logic                     perm_done;

    modport master (
        output opcode, addr, data_in, perm_state_i, perm_done,
        input  data_out, ready, busy, err, perm_start, perm_state_o
    );

    modport slave (
        input  opcode, addr, data_in, perm_state_i, perm_done,
        output data_out, ready, busy, err, perm_start, perm_state_o
    );
endinterface

// File: rtl/photon_hash_ctrl_wdog.sv
// WAIT-cycle watchdog: counts enabled cycles, flags the TIMEOUT-th one.
module photon_ctrl_wdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset)        r_cnt <= '0;
        else if (i_clear)  r_cnt <= '0;
        else if (i_enable) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_expired_c = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/photon_hash_ctrl.sv
// PHOTON hash controller: state word file, command decode and permutation-core sequencing.
// Optional WAIT watchdog enabled by defining PHOTON_CTRL_TIMEOUT_EN.
module photon_hash_ctrl
    import photon_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NWORDS  = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    photon_hash_ctrl_if.slave bus
);
    localparam int unsigned ADDR_W = addr_w(NWORDS);

    state_e                        r_state, w_state_nxt;
    logic [NWORDS-1:0][DATA_W-1:0] r_words;
    logic [DATA_W-1:0]             r_data_out, w_data_out_nxt;
    logic                          r_ready, w_ready_nxt;
    logic                          r_err, w_err_nxt;
    logic                          r_busy, r_perm_start;
    logic                          w_wr_en, w_capture, w_clear;
    logic                          w_addr_ok, w_bad_op, w_cmd, w_expired;

    assign w_addr_ok = ({1'b0, bus.addr} < (ADDR_W + 1)'(NWORDS));
    assign w_bad_op  = (bus.opcode > OP_CLEAR);
    assign w_cmd     = (bus.opcode == OP_WRITE) || (bus.opcode == OP_READ) || (bus.opcode == OP_HASH);

`ifdef PHOTON_CTRL_TIMEOUT_EN
    photon_ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (r_state != ST_WAIT),
        .i_enable    (r_state == ST_WAIT),
        .o_expired_c (w_expired)
    );
`else
    // No watchdog: WAIT only ends on perm_done, CLEAR or reset.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_expired        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_data_out   <= '0;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_perm_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_data_out   <= w_data_out_nxt;
            r_ready      <= w_ready_nxt;
            r_err        <= w_err_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_perm_start <= (w_state_nxt == ST_START);
        end
    end

    // CLEAR has top priority in every state, including over perm_done.
    always_comb begin
        w_state_nxt    = r_state;
        w_data_out_nxt = r_data_out;
        w_ready_nxt    = r_ready;
        w_err_nxt      = r_err;
        w_wr_en        = 1'b0;
        w_capture      = 1'b0;
        w_clear        = 1'b0;
        if (bus.opcode == OP_CLEAR) begin
            w_state_nxt    = ST_IDLE;
            w_data_out_nxt = '0;
            w_ready_nxt    = 1'b0;
            w_err_nxt      = 1'b0;
            w_clear        = 1'b1;
        end else begin
            if (w_bad_op) w_err_nxt = 1'b1;
            case (r_state)
                ST_IDLE: begin
                    case (bus.opcode)
                        OP_WRITE: begin
                            if (w_addr_ok) begin
                                w_wr_en     = 1'b1;
                                w_ready_nxt = 1'b0;
                            end else begin
                                w_err_nxt   = 1'b1;
                            end
                        end
                        OP_READ: begin
                            w_data_out_nxt = w_addr_ok ? r_words[bus.addr] : '0;
                            if (!w_addr_ok) w_err_nxt = 1'b1;
                        end
                        OP_HASH: begin
                            w_ready_nxt = 1'b0;
                            w_state_nxt = ST_START;
                        end
                        default: ;
                    endcase
                end
                ST_START: begin
                    if (w_cmd) w_err_nxt = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_cmd) w_err_nxt = 1'b1;
                    if (bus.perm_done) begin
                        w_capture   = 1'b1;
                        w_ready_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_expired) begin
                        w_err_nxt   = 1'b1;
                        w_ready_nxt = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)         r_words <= '0;
        else if (w_clear)   r_words <= '0;
        else if (w_capture) r_words <= bus.perm_state_i;
        else if (w_wr_en)   r_words[bus.addr] <= bus.data_in;
    end

    assign bus.perm_state_o = r_words;
    assign bus.data_out     = r_data_out;
    assign bus.ready        = r_ready;
    assign bus.busy         = r_busy;
    assign bus.err          = r_err;
    assign bus.perm_start   = r_perm_start;
endmodule

// File: doc/photon_hash_ctrl.md
PHOTON_HASH_CTRL -- requirements
Module: photon_hash_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one state word.
REQ-002 SHALL have parameter NWORDS, default 8, number of state words; ADDR_W = max(1, clog2(NWORDS)).
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum WAIT cycles (used only with REQ-030).
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports opcode in 3 (command); addr in ADDR_W (word index); data_in in DATA_W (write data).
REQ-007 SHALL have ports data_out out DATA_W (read data); ready out 1 (digest valid); busy out 1 (permutation in flight); err out 1 (sticky error).
REQ-008 SHALL have ports perm_start out 1 (one-cycle start pulse); perm_state_o out NWORDS*DATA_W (state to core, word 0 in LSBs).
REQ-009 SHALL have ports perm_state_i in NWORDS*DATA_W (result from core); perm_done in 1 (one-cycle completion pulse).

Function
REQ-010 SHALL decode opcodes NOP=0, WRITE=1, READ=2, HASH=3, CLEAR=4; codes 5-7 SHALL act as NOP and set err.
REQ-011 SHALL hold NWORDS x DATA_W state registers, driven continuously onto perm_state_o.
REQ-012 SHALL implement FSM IDLE -> START -> WAIT -> IDLE; busy SHALL be 1 in START and WAIT.
REQ-013 WRITE in IDLE SHALL store data_in into word addr at the clock edge and clear ready.
REQ-014 READ in IDLE SHALL load word addr into data_out at the edge (1-cycle latency); data_out SHALL otherwise hold.
REQ-015 addr >= NWORDS SHALL make WRITE a no-op and READ return 0, and SHALL set err.
REQ-016 HASH in IDLE SHALL clear ready and enter START; START SHALL assert perm_start for exactly one cycle, then enter WAIT.
REQ-017 In WAIT, perm_done=1 SHALL capture perm_state_i into all words, set ready, and return to IDLE; ready rises the edge after perm_done.
REQ-018 perm_done outside WAIT SHALL be ignored.
REQ-019 WRITE, READ or HASH while busy SHALL be dropped and set err; state, FSM and data_out unchanged.
REQ-020 CLEAR SHALL be accepted in any state: zero all words and data_out, clear ready and err, go to IDLE.
REQ-021 CLEAR coincident with perm_done SHALL win; the result is discarded.
REQ-022 err SHALL stay set until CLEAR or reset; HASH does not clear it.

Reset
REQ-023 reset=0 at an edge SHALL force IDLE, all words 0, data_out 0, ready 0, busy 0, err 0, perm_start 0.
REQ-024 Reset during START/WAIT SHALL abort; a later perm_done SHALL be ignored (REQ-018).

Configuration
REQ-030 With PHOTON_CTRL_TIMEOUT_EN defined, a WAIT cycle counter SHALL return to IDLE with err=1, ready=0, words unchanged when TIMEOUT WAIT cycles elapse without perm_done.
REQ-031 Without PHOTON_CTRL_TIMEOUT_EN, no counter SHALL be built and WAIT SHALL persist until perm_done, CLEAR or reset.

Structure
REQ-040 Package photon_ctrl_pkg SHALL hold the opcode enum (3-bit) and the FSM state enum.
REQ-041 Timeout counter SHALL be sub-module photon_ctrl_wdog (clear, enable, expired), instantiated only under PHOTON_CTRL_TIMEOUT_EN.

Verification
REQ-050 Reset, WRITE words 0-6 = 0, word 7 = 0x00382020, HASH; model core returns state XOR 0xA5A5A5A5 five cycles after perm_start -> one perm_start pulse, ready rises the edge after perm_done, READ 0-7 yields 0xA5A5A5A5 x7 and 0xA59D8585.
REQ-051 HASH, then WRITE addr 2 = 0xDEADBEEF during WAIT -> err=1, word 2 equals the hash result, ready still rises.
REQ-052 HASH, CLEAR in the same cycle as perm_done -> IDLE, READ 7 = 0, ready=0, err=0.
REQ-053 NWORDS=6: WRITE addr 7, READ addr 6 -> err=1, data_out=0, no word changed; opcode 6 -> err=1.
REQ-054 PHOTON_CTRL_TIMEOUT_EN, TIMEOUT=16, core never responds -> busy drops after 16 WAIT cycles, err=1, ready=0, words intact.
REQ-055 reset=0 during WAIT, then late perm_done -> all outputs at reset values, no capture.
